// File: rtl/branch_resolve_unit.sv
// Branch resolution for the 5-stage pipeline: carries each branch's prediction from D to M,
// checks it against the actual outcome, issues the redirect/flush and trains the predictor.
module branch_resolve_unit #(
    parameter logic [31:0] FALLTHRU_OFS = 32'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallE,
    input  logic        stallM,
    input  logic        flushE,
    input  logic        flushM,
    input  logic        branchD,
    input  logic        pred_takeD,
    input  logic [31:0] pcD,
    input  logic [31:0] targetD,
    input  logic        actual_takeE,
    output logic        branchM,
    output logic        actual_takeM,
    output logic [31:0] pcM,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flushD_o,
    output logic        flushF_o,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    logic        r_e_valid;
    logic        r_e_pred;
    logic [31:0] r_e_pc;
    logic [31:0] r_e_target;

    logic        r_m_valid;
    logic        r_m_pred;
    logic        r_m_taken;
    logic        r_m_done;
    logic [31:0] r_m_pc;
    logic [31:0] r_m_target;

    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    logic        w_resolve;
    logic        w_mispredict;
    logic [31:0] w_correct_pc;

    assign w_resolve    = r_m_valid & ~r_m_done;
    assign w_mispredict = w_resolve & (r_m_pred != r_m_taken);
    assign w_correct_pc = r_m_taken ? r_m_target : (r_m_pc + FALLTHRU_OFS);

    assign branchM      = w_resolve;
    assign actual_takeM = r_m_taken;
    assign pcM          = r_m_pc;
    assign redirect     = w_mispredict;
    assign flushD_o     = w_mispredict;
    assign flushF_o     = w_mispredict;
    assign redirect_pc  = w_mispredict ? w_correct_pc : 32'd0;
    assign branch_cnt   = r_branch_cnt;
    assign mispred_cnt  = r_mispred_cnt;

    // A redirect bubbles only the wrong-path instruction entering E; the delay slot already in E survives.
    always_ff @(posedge clk) begin
        if (rst || flushE || w_mispredict) begin
            r_e_valid  <= 1'b0;
            r_e_pred   <= 1'b0;
            r_e_pc     <= 32'd0;
            r_e_target <= 32'd0;
        end else if (!stallE) begin
            r_e_valid  <= branchD;
            r_e_pred   <= pred_takeD;
            r_e_pc     <= pcD;
            r_e_target <= targetD;
        end
    end

    // done marks a held branch that has already strobed, so a stall cannot repeat the redirect.
    always_ff @(posedge clk) begin
        if (rst || flushM || (stallE && !stallM)) begin
            r_m_valid  <= 1'b0;
            r_m_pred   <= 1'b0;
            r_m_taken  <= 1'b0;
            r_m_done   <= 1'b0;
            r_m_pc     <= 32'd0;
            r_m_target <= 32'd0;
        end else if (stallM) begin
            r_m_done   <= r_m_done | w_resolve;
        end else begin
            r_m_valid  <= r_e_valid;
            r_m_pred   <= r_e_pred;
            r_m_taken  <= actual_takeE;
            r_m_done   <= 1'b0;
            r_m_pc     <= r_e_pc;
            r_m_target <= r_e_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt  <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            if (w_resolve && (r_branch_cnt != 32'hFFFF_FFFF))
                r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_mispredict && (r_mispred_cnt != 32'hFFFF_FFFF))
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

endmodule
